fc_sequencer: RTL

FC_SEQUENCER -- requirements
Module: fc_sequencer

---
 rtl/fc_sequencer_if.sv | 38 +++
 rtl/fc_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fc_sequencer_if.sv
// Bus between the FC-layer sequencer and its flatten/weight/bias RAMs, MAC, score buffer and host.
// The sequencer takes the master side; the environment takes the slave side.
interface fc_sequencer_if #(
   parameter int BITWIDTH = 8,
   parameter int FLAT_AW  = 8,
   parameter int W_AW     = 10,
   parameter int B_AW     = 8,
   parameter int OUT_AW   = 4
);
   logic                start;
   logic                busy;
   logic                done;
   logic                flat_re;
   logic [FLAT_AW-1:0]  flat_addr;
   logic                w_re;
   logic [W_AW-1:0]     w_addr;
   logic                b_re;
   logic [B_AW-1:0]     b_addr;
   logic                mac_ena_add;
   logic [BITWIDTH-1:0] mac_result;
   logic                out_we;
   logic [OUT_AW-1:0]   out_addr;
   logic [BITWIDTH-1:0] out_data;
   logic [OUT_AW-1:0]   class_idx;
   logic                class_valid;

   modport master (
      input  start, mac_result,
      output busy, done, flat_re, flat_addr, w_re, w_addr, b_re, b_addr,
             mac_ena_add, out_we, out_addr, out_data, class_idx, class_valid
   );

   modport slave (
      output start, mac_result,
      input  busy, done, flat_re, flat_addr, w_re, w_addr, b_re, b_addr,
             mac_ena_add, out_we, out_addr, out_data, class_idx, class_valid
   );
endinterface

// File: rtl/fc_sequencer.sv
// Fully-connected layer sequencer: streams inputs/weights/bias into a MAC per neuron and stores scores.
// Define FC_SEQ_ARGMAX_EN to add the running argmax over stored scores (class_idx/class_valid).
module fc_sequencer #(
   parameter int IN_LEN    = 84,
   parameter int OUT_LEN   = 10,
   parameter int BITWIDTH  = 8,
   parameter int MAC_LAT   = 3,
   parameter int BIAS_BASE = 204,
   parameter int FLAT_AW   = 8,
   parameter int W_AW      = 10,
   parameter int B_AW      = 8,
   parameter int OUT_AW    = 4
) (
   input  logic          clk,
   input  logic          rstn,
   fc_sequencer_if.master bus
);
   typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, STORE, FIN} state_e;

   localparam int DCW = $clog2(MAC_LAT + 1) + 1;

   state_e              state_q, state_d;
   logic [FLAT_AW-1:0]  i_q, i_d;
   logic [OUT_AW-1:0]   n_q, n_d;
   logic [W_AW-1:0]     w_q, w_d;
   logic [B_AW-1:0]     b_q, b_d;
   logic [DCW-1:0]      dcnt_q, dcnt_d;
   logic                ena_q, ena_d;
   logic                last_in, last_n;
   logic [BITWIDTH-1:0] score;

   assign last_in = (i_q == FLAT_AW'(IN_LEN - 1));
   assign last_n  = (n_q == OUT_AW'(OUT_LEN - 1));
   assign score   = bus.mac_result;

   // Input index and weight/bias addresses are held outside ACCUM so the RAM ports stay stable.
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      n_d     = n_q;
      w_d     = w_q;
      b_d     = b_q;
      dcnt_d  = dcnt_q;
      ena_d   = !(state_q == ACCUM && i_q == '0);
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               i_d     = '0;
               n_d     = '0;
               w_d     = '0;
               b_d     = B_AW'(BIAS_BASE);
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (last_in) begin
               dcnt_d  = '0;
               state_d = DRAIN;
            end else begin
               i_d = i_q + 1'b1;
               w_d = w_q + 1'b1;
            end
         end
         DRAIN: begin
            if (dcnt_q == DCW'(MAC_LAT)) state_d = STORE;
            else                         dcnt_d  = dcnt_q + 1'b1;
         end
         STORE: begin
            if (last_n) begin
               state_d = FIN;
            end else begin
               n_d     = n_q + 1'b1;
               i_d     = '0;
               w_d     = w_q + 1'b1;
               b_d     = b_q + 1'b1;
               state_d = ACCUM;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         i_q     <= '0;
         n_q     <= '0;
         w_q     <= '0;
         b_q     <= '0;
         dcnt_q  <= '0;
         ena_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         n_q     <= n_d;
         w_q     <= w_d;
         b_q     <= b_d;
         dcnt_q  <= dcnt_d;
         ena_q   <= ena_d;
      end
   end

   assign bus.busy        = (state_q != IDLE);
   assign bus.done        = (state_q == FIN);
   assign bus.flat_re     = (state_q == ACCUM);
   assign bus.w_re        = (state_q == ACCUM);
   assign bus.b_re        = (state_q == ACCUM);
   assign bus.flat_addr   = i_q;
   assign bus.w_addr      = w_q;
   assign bus.b_addr      = b_q;
   assign bus.mac_ena_add = ena_q;
   assign bus.out_we      = (state_q == STORE);
   assign bus.out_addr    = n_q;
   assign bus.out_data    = (state_q == STORE) ? score : '0;

`ifdef FC_SEQ_ARGMAX_EN
   logic [BITWIDTH-1:0] max_q, max_d;
   logic [OUT_AW-1:0]   best_q, best_d, cls_q, cls_d;
   logic                cvld_q, cvld_d, take;

   // The final winner is resolved combinationally in the last STORE so it is visible during FIN.
   always_comb begin
      max_d  = max_q;
      best_d = best_q;
      cls_d  = cls_q;
      cvld_d = cvld_q;
      take   = (n_q == '0) || (score > max_q);
      if (state_q == IDLE && bus.start) cvld_d = 1'b0;
      if (state_q == STORE) begin
         if (take) begin
            max_d  = score;
            best_d = n_q;
         end
         if (last_n) begin
            cls_d  = take ? n_q : best_q;
            cvld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         max_q  <= '0;
         best_q <= '0;
         cls_q  <= '0;
         cvld_q <= 1'b0;
      end else begin
         max_q  <= max_d;
         best_q <= best_d;
         cls_q  <= cls_d;
         cvld_q <= cvld_d;
      end
   end

   assign bus.class_idx   = cls_q;
   assign bus.class_valid = cvld_q;
`else
   assign bus.class_idx   = '0;
   assign bus.class_valid = 1'b0;
`endif
endmodule
